// File: rtl/fifo_rd_stream_pkg.sv
// Shared types for the read-side FIFO drain controller: word width,
// controller state encoding, word type and the debug view of the controller.
package fifo_pkg;

  localparam int DATA_WIDTH  = 24;
  localparam int FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } rd_state_t;

  typedef logic [DATA_WIDTH-1:0] fifo_word_t;

  // Internal controller state, exported so checkers can observe it directly.
  typedef struct packed {
    rd_state_t              state;
    logic [1:0]             occ;
    logic                   inflight;
    logic [FRAME_CNT_W-1:0] frame_cnt;
  } rd_dbg_t;

  // Next value of a frame position counter that wraps after frame_len words.
  function automatic logic [FRAME_CNT_W-1:0] frame_wrap(
    input logic [FRAME_CNT_W-1:0] cnt,
    input int                     frame_len
  );
    return (cnt == FRAME_CNT_W'(frame_len - 1)) ? '0 : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Output word stream of the FIFO drain controller.
//
// Handshake: the master raises m_valid with m_data/m_last and holds all three
// stable until the cycle the slave has m_ready high; the word transfers on
// that cycle (m_valid && m_ready). m_valid never depends on m_ready, and
// m_ready may be asserted with or without m_valid.
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH
) ();

  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);

endinterface

// File: rtl/fifo_rd_stream_skid_buf.sv
// Two-entry in-order buffer between the FIFO read port and the output stream.
// Entry 0 is the head and drives the stream; entry 1 holds the second word
// while the head is stalled. The writer guarantees space before writing.
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] ent0;
  logic [DATA_WIDTH-1:0] ent1;
  logic                  pop;

  assign pop     = m_valid && m_ready;
  assign m_valid = (occ != 2'd0);
  assign m_data  = ent0;

  // Shift or fill the two entries according to occupancy, write and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent0 <= '0;
      ent1 <= '0;
      occ  <= 2'd0;
    end else begin
      case (occ)
        2'd0: begin
          if (wr_en) begin
            ent0 <= wr_data;
            occ  <= 2'd1;
          end
        end
        2'd1: begin
          case ({wr_en, pop})
            2'b10: begin
              ent1 <= wr_data;
              occ  <= 2'd2;
            end
            2'b01: occ <= 2'd0;
            2'b11: ent0 <= wr_data;
            default: ;
          endcase
        end
        2'd2: begin
          // A write into a full buffer cannot happen: the pop credit
          // never lets more than two words be outstanding.
          if (pop) begin
            ent0 <= ent1;
            if (wr_en) ent1 <= wr_data;
            else       occ  <= 2'd1;
          end
        end
        default: occ <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain controller for the async FIFO. Pops words only when the
// FIFO is non-empty by both its registered and its look-ahead empty flags and
// when buffer credit is available, then presents them as a valid/ready
// stream with frame-end markers and a delivered-word counter.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int FRAME_LEN  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic                  fifo_almost_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  fifo_rd_stream_if.master      m_if,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_count,
  output rd_dbg_t               dbg
);

  rd_state_t              state;
  logic                   inflight;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic [1:0]             occ;
  logic                   hs;
  logic [2:0]             credit_used;
  logic [2:0]             occ_nxt;
  logic                   drained;

  assign hs = m_if.m_valid && m_if.m_ready;

  // Words already committed: buffered plus the one arriving this cycle.
  // Pops depend only on registered state and FIFO flags, never on m_ready.
  assign credit_used = {1'b0, occ} + {2'b00, inflight};
  assign fifo_rd_en  = (state == RUN) && !fifo_empty && !fifo_almost_empty &&
                       (credit_used < 3'd2);

  // Occupancy after this edge; lets the controller leave STOP on the same
  // edge that delivers the last buffered word.
  assign occ_nxt = {1'b0, occ} + {2'b00, inflight} - {2'b00, hs};
  assign drained = (occ_nxt == 3'd0) && !fifo_rd_en;

  // Frame marker is attached at the output, so it follows handshakes only.
  assign m_if.m_last = m_if.m_valid && (frame_cnt == FRAME_CNT_W'(FRAME_LEN - 1));

  assign dbg.state     = state;
  assign dbg.occ       = occ;
  assign dbg.inflight  = inflight;
  assign dbg.frame_cnt = frame_cnt;

  // FIFO data arrives the cycle after the pop and is written unconditionally.
  stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (inflight),
    .wr_data (fifo_data),
    .m_valid (m_if.m_valid),
    .m_ready (m_if.m_ready),
    .m_data  (m_if.m_data),
    .occ     (occ)
  );

  // Controller FSM with in-flight tracking, frame position, delivered count
  // and a registered busy flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      inflight   <= 1'b0;
      frame_cnt  <= '0;
      word_count <= '0;
      busy       <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      if (hs) begin
        frame_cnt  <= frame_wrap(frame_cnt, FRAME_LEN);
        word_count <= word_count + 1'b1;
      end
      case (state)
        IDLE: begin
          if (enable) begin
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            busy  <= (occ_nxt != 3'd0);
          end
        end
        RUN: begin
          // A pop issued on the cycle enable falls still completes in STOP.
          if (!enable) state <= STOP;
          busy <= 1'b1;
        end
        STOP: begin
          if (enable) begin
            state <= RUN;
            busy  <= 1'b1;
          end else if (drained) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural model of the FIFO
// read port (registered data_out, look-ahead and registered empty flags).
module tb_fifo_rd_stream;
  import fifo_pkg::*;

  localparam int W    = 24;
  localparam int FLEN = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          enable;
  logic          fifo_empty;
  logic          fifo_almost_empty;
  logic [W-1:0]  fifo_data;
  logic          fifo_rd_en;
  logic          busy;
  logic [15:0]   word_count;
  rd_dbg_t       dbg;

  fifo_rd_stream_if #(.DATA_WIDTH(W)) s_if ();

  fifo_rd_stream #(
    .DATA_WIDTH (W),
    .FRAME_LEN  (FLEN),
    .CNT_WIDTH  (16)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .enable            (enable),
    .fifo_empty        (fifo_empty),
    .fifo_almost_empty (fifo_almost_empty),
    .fifo_data         (fifo_data),
    .fifo_rd_en        (fifo_rd_en),
    .m_if              (s_if),
    .busy              (busy),
    .word_count        (word_count),
    .dbg               (dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int errors   = 0;
  int pops     = 0;
  int hs_cnt   = 0;
  int last_cnt = 0;
  int overread = 0;
  int bad_pop  = 0;
  int stray    = 0;
  int max_out  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push(input logic [W-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    fifo_almost_empty <= 1'b0;
  endtask

  // One clock cycle: sample before the edge, update the FIFO model after it.
  task automatic tick();
    logic pop, hs;
    logic [W-1:0] e;
    int out_now;
    #2;
    pop = fifo_rd_en;
    hs  = s_if.m_valid && s_if.m_ready;
    if (pop) begin
      pops++;
      if (fifo_q.size() == 0) overread++;
      if (fifo_almost_empty || fifo_empty) bad_pop++;
    end
    if (!s_if.m_valid && s_if.m_last) stray++;
    out_now = pops - hs_cnt;
    if (out_now > max_out) max_out = out_now;
    if (hs) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 32'(s_if.m_data), 32'hdead);
      end else begin
        e = exp_q.pop_front();
        chk("m_data", 32'(s_if.m_data), 32'(e));
      end
      chk("m_last", 32'(s_if.m_last), 32'((hs_cnt % FLEN) == FLEN - 1));
      if (s_if.m_last) last_cnt++;
      hs_cnt++;
    end
    @(posedge clk);
    fifo_empty <= fifo_almost_empty;
    if (pop && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
    fifo_almost_empty <= (fifo_q.size() == 0);
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    chk("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int snap;
    reset             = 1'b1;
    enable            = 1'b0;
    s_if.m_ready      = 1'b0;
    fifo_empty        <= 1'b1;
    fifo_almost_empty <= 1'b1;
    fifo_data         <= '0;

    // Reset values
    #12;
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_m_valid", 32'(s_if.m_valid), 32'd0);
    chk("rst_m_last", 32'(s_if.m_last), 32'd0);
    chk("rst_m_data", 32'(s_if.m_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_state", 32'(dbg.state), 32'(IDLE));
    chk("rst_frame_cnt", 32'(dbg.frame_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Three words, free-flowing output; last pop must see almost_empty stop it
    enable       = 1'b1;
    s_if.m_ready = 1'b1;
    snap = pops;
    for (int i = 1; i <= 3; i++) push(W'(i));
    drain(30);
    chk("t1_pops", 32'(pops - snap), 32'd3);
    chk("t1_word_count", 32'(word_count), 32'd3);
    chk("t1_overread", 32'(overread), 32'd0);
    chk("t1_bad_pop", 32'(bad_pop), 32'd0);

    // Back-pressure: only two pops outstanding, then release
    s_if.m_ready = 1'b0;
    snap = pops;
    for (int i = 0; i < 10; i++) push(W'(32'h100 + i));
    for (int i = 0; i < 8; i++) tick();
    chk("bp_pops", 32'(pops - snap), 32'd2);
    chk("bp_rd_en_low", 32'(fifo_rd_en), 32'd0);
    chk("bp_occ", 32'(dbg.occ), 32'd2);
    chk("bp_head_held", 32'(s_if.m_data), 32'h100);
    s_if.m_ready = 1'b1;
    drain(60);
    chk("bp_word_count", 32'(word_count), 32'd13);

    // Asynchronous reset with a full buffer
    s_if.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(W'(32'h400 + i));
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_occ", 32'(dbg.occ), 32'd2);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_m_valid", 32'(s_if.m_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_word_count", 32'(word_count), 32'd0);
    chk("arst_state", 32'(dbg.state), 32'(IDLE));
    chk("arst_rd_en", 32'(fifo_rd_en), 32'd0);
    fifo_q.delete();
    exp_q.delete();
    fifo_empty        <= 1'b1;
    fifo_almost_empty <= 1'b1;
    fifo_data         <= '0;
    pops     = 0;
    hs_cnt   = 0;
    last_cnt = 0;
    @(negedge clk);
    reset = 1'b0;

    // Frames of 4: nine words mark words 4 and 8
    s_if.m_ready = 1'b1;
    for (int i = 0; i < 9; i++) push(W'(32'h200 + i));
    drain(60);
    chk("fr_last_count", 32'(last_cnt), 32'd2);
    chk("fr_frame_cnt", 32'(dbg.frame_cnt), 32'd1);
    chk("fr_word_count", 32'(word_count), 32'd9);

    // enable falls on the cycle of a pop while stalled
    s_if.m_ready = 1'b0;
    push(W'(32'h300));
    push(W'(32'h301));
    tick();
    enable = 1'b0;
    #1;
    chk("stop_pop_issued", 32'(fifo_rd_en), 32'd1);
    chk("stop_state_run", 32'(dbg.state), 32'(RUN));
    tick();
    chk("stop_state", 32'(dbg.state), 32'(STOP));
    chk("stop_inflight", 32'(dbg.inflight), 32'd1);
    chk("stop_busy", 32'(busy), 32'd1);
    chk("stop_no_pop", 32'(fifo_rd_en), 32'd0);
    tick();
    chk("stop_captured_occ", 32'(dbg.occ), 32'd1);
    chk("stop_m_valid", 32'(s_if.m_valid), 32'd1);
    chk("stop_m_data", 32'(s_if.m_data), 32'h300);
    for (int i = 0; i < 3; i++) tick();
    chk("stop_hold_state", 32'(dbg.state), 32'(STOP));
    chk("stop_hold_rd_en", 32'(fifo_rd_en), 32'd0);
    s_if.m_ready = 1'b1;
    #1;
    chk("stop_busy_at_hs", 32'(busy), 32'd1);
    tick();
    chk("idle_state", 32'(dbg.state), 32'(IDLE));
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_m_valid", 32'(s_if.m_valid), 32'd0);
    chk("idle_word_count", 32'(word_count), 32'd10);

    // Global invariants
    chk("overread_total", 32'(overread), 32'd0);
    chk("bad_pop_total", 32'(bad_pop), 32'd0);
    chk("stray_last", 32'(stray), 32'd0);
    chk("max_outstanding_le2", 32'(max_out <= 2), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
